// File: rtl/crc_stream_engine.sv
// Bit-serial CRC engine: accepts DATA_W-bit words MSB first and shifts one bit per cycle.
// It produces a final CRC in generate mode, or a residue-based verdict in check mode.
module crc_stream_engine #(
  parameter int                 CRC_W   = 32,
  parameter logic [CRC_W-1:0]   POLY    = CRC_W'(32'h04C11DB7),
  parameter logic [CRC_W-1:0]   INIT    = {CRC_W{1'b0}},
  parameter logic [CRC_W-1:0]   XOROUT  = {CRC_W{1'b0}},
  parameter logic [CRC_W-1:0]   RESIDUE = {CRC_W{1'b0}},
  parameter int                 DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid,
  output logic              crc_ok,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic [CRC_W-1:0]   r_crc;
  logic [CRC_W-1:0]   r_crc_out;
  logic [DATA_W-1:0]  r_data;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last;
  logic               r_mode;
  logic               r_crc_valid;
  logic               r_crc_ok;
  logic               r_in_ready;
  logic               r_busy;

  logic               w_fb;
  logic [CRC_W-1:0]   w_crc_next;

  // One serial LFSR step; the polynomial's top bit is implied by the shift-out.
  always_comb begin
    w_fb       = r_crc[CRC_W-1] ^ r_data[DATA_W-1];
    w_crc_next = (r_crc << 1) ^ (w_fb ? POLY : {CRC_W{1'b0}});
  end

  // Frame FSM; outputs are registered so results appear exactly in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_crc       <= {CRC_W{1'b0}};
      r_crc_out   <= {CRC_W{1'b0}};
      r_data      <= {DATA_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_last      <= 1'b0;
      r_mode      <= 1'b0;
      r_crc_valid <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_crc_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_crc      <= INIT;
            r_mode     <= mode;
            r_state    <= ACCEPT;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end else begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            r_data     <= in_data;
            r_last     <= in_last;
            r_cnt      <= CNT_W'(DATA_W - 1);
            r_state    <= SHIFT;
            r_in_ready <= 1'b0;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        SHIFT: begin
          r_crc  <= w_crc_next;
          r_data <= r_data << 1;
          if (r_cnt == {CNT_W{1'b0}}) begin
            if (r_last) begin
              // Result is taken from the post-shift value so it is ready during DONE.
              r_state     <= DONE;
              r_crc_valid <= 1'b1;
              r_crc_out   <= w_crc_next ^ XOROUT;
              r_crc_ok    <= (~r_mode) & (w_crc_next == RESIDUE);
            end else begin
              r_state    <= ACCEPT;
              r_in_ready <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign crc_out   = r_crc_out;
  assign crc_valid = r_crc_valid;
  assign crc_ok    = r_crc_ok;
  assign busy      = r_busy;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: three parameterisations share one input stream and are
// compared against a byte-oriented CRC reference model.
module tb_crc_stream_engine;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst, start, mode, in_valid, in_last;
  logic [7:0]  in_data;

  logic        rdy_d, val_d, ok_d, busy_d;
  logic [31:0] out_d;
  logic        rdy_m, val_m, ok_m, busy_m;
  logic [31:0] out_m;
  logic        rdy_p, val_p, ok_p, busy_p;
  logic [31:0] out_p;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] msg_q[$];

  always #5 clk = ~clk;

  crc_stream_engine u_def (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_d), .crc_out(out_d),
    .crc_valid(val_d), .crc_ok(ok_d), .busy(busy_d));

  crc_stream_engine #(.INIT(32'hFFFFFFFF)) u_mpeg (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_m), .crc_out(out_m),
    .crc_valid(val_m), .crc_ok(ok_m), .busy(busy_m));

  crc_stream_engine #(.XOROUT(32'hFFFFFFFF)) u_posix (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_p), .crc_out(out_p),
    .crc_valid(val_p), .crc_ok(ok_p), .busy(busy_p));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register contents after the whole message, processed a byte at a time.
  function automatic logic [31:0] model_reg(input logic [31:0] init);
    logic [31:0] r;
    r = init;
    foreach (msg_q[i]) begin
      r = r ^ {msg_q[i], 24'h000000};
      for (int b = 0; b < 8; b++)
        r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    end
    return r;
  endfunction

  task automatic check_results(input logic m);
    logic [31:0] rd, rm, rp;
    rd = model_reg(32'h00000000);
    rm = model_reg(32'hFFFFFFFF);
    rp = model_reg(32'h00000000);
    chk("def_out",   out_d, rd);
    chk("mpeg_out",  out_m, rm);
    chk("posix_out", out_p, rp ^ 32'hFFFFFFFF);
    chk("def_ok",    {31'd0, ok_d}, {31'd0, (m == 1'b0) && (rd == 32'h0)});
    chk("mpeg_ok",   {31'd0, ok_m}, {31'd0, (m == 1'b0) && (rm == 32'h0)});
    chk("posix_ok",  {31'd0, ok_p}, {31'd0, (m == 1'b0) && (rp == 32'h0)});
  endtask

  // Streams msg_q as one frame, holding in_valid high through SHIFT, and checks latency/results.
  task automatic run_frame(input logic m, input bit poke);
    int waits;
    logic [31:0] held;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'($urandom);
    for (int i = 0; i < msg_q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      in_data  = msg_q[i];
      in_last  = (i == msg_q.size() - 1);
      in_valid = 1'b1;
      waits = 0;
      while (!rdy_d && waits < 50) begin
        @(negedge clk);
        waits++;
      end
      if (waits >= 50) begin
        chk("ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      if (i == msg_q.size() - 1) begin
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
      end else begin
        @(negedge clk);
        if (poke && i == 0) begin
          start = 1'b1;
          mode  = ~m;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k < 8) chk("valid_early", {31'd0, val_d}, 32'd0);
    end
    chk("valid_at_latency", {31'd0, val_d}, 32'd1);
    chk("valid_mpeg", {31'd0, val_m}, 32'd1);
    check_results(m);
    held = out_d;
    @(posedge clk);
    #1;
    chk("valid_one_cycle", {31'd0, val_d}, 32'd0);
    chk("idle_busy", {31'd0, busy_d}, 32'd0);
    chk("out_hold", out_d, held);
  endtask

  task automatic load_check_string();
    msg_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  endtask

  initial begin
    int pulses;
    logic [31:0] c;
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",   out_d, 32'h0);
    chk("rst_flags", {28'd0, rdy_d, val_d, ok_d, busy_d}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single word 0x01, generate mode.
    msg_q = {8'h01};
    run_frame(1'b1, 1'b0);
    chk("single_01", out_d, 32'h04C11DB7);

    // "123456789" in generate mode, with a start pulse while busy.
    load_check_string();
    run_frame(1'b1, 1'b1);
    chk("mpeg2_check", out_m, 32'h0376E6E7);
    chk("posix_check", out_p, 32'h765E7680);

    // Check mode: message followed by its MPEG-2 CRC, then one flipped bit.
    load_check_string();
    msg_q.push_back(8'h03); msg_q.push_back(8'h76);
    msg_q.push_back(8'hE6); msg_q.push_back(8'hE7);
    run_frame(1'b0, 1'b1);
    chk("mpeg_good_frame", {31'd0, ok_m}, 32'd1);
    msg_q[2] = msg_q[2] ^ 8'h10;
    run_frame(1'b0, 1'b0);
    chk("mpeg_bad_frame", {31'd0, ok_m}, 32'd0);

    // Reset in the 4th SHIFT cycle.
    msg_q = {8'hAA, 8'hBB};
    @(negedge clk);
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_data = 8'hAA; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out",   out_d, 32'h0);
    chk("midrst_flags", {28'd0, rdy_d, val_d, ok_d, busy_d}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (val_d) pulses++;
    end
    chk("midrst_no_pulse", pulses, 32'd0);
    run_frame(1'b1, 1'b0);

    // Random frames; check-mode frames carry the default instance's CRC.
    for (int f = 0; f < 8; f++) begin
      logic m;
      msg_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++)
        msg_q.push_back(8'($urandom));
      m = 1'($urandom);
      if (!m) begin
        c = model_reg(32'h0);
        msg_q.push_back(c[31:24]); msg_q.push_back(c[23:16]);
        msg_q.push_back(c[15:8]);  msg_q.push_back(c[7:0]);
      end
      run_frame(m, 1'($urandom));
      if (!m) chk("rand_def_ok", {31'd0, ok_d}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 32: CRC register width in bits.
REQ-002 SHALL have parameter POLY, default 32'h04C11DB7: generator polynomial with implicit top bit, CRC_W bits.
REQ-003 SHALL have parameter INIT, default 0: register preload value at frame start.
REQ-004 SHALL have parameter XOROUT, default 0: value XORed into the register to form crc_out.
REQ-005 SHALL have parameter RESIDUE, default 0: register value that signals a good frame in check mode.
REQ-006 SHALL have parameter DATA_W, default 8: input word width; legal range 1..64.
REQ-007 SHALL have port clk, input, 1: rising-edge clock.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port start, input, 1: begin frame; accepted only in IDLE.
REQ-010 SHALL have port mode, input, 1: 1 = generate, 0 = check; sampled when start is accepted.
REQ-011 SHALL have port in_data, input, DATA_W: message word, processed MSB first.
REQ-012 SHALL have port in_valid, input, 1: in_data and in_last are valid.
REQ-013 SHALL have port in_last, input, 1: current word is the final word of the frame.
REQ-014 SHALL have port in_ready, output, 1: engine can accept a word.
REQ-015 SHALL have port crc_out, output, CRC_W: final CRC (register XOR XOROUT).
REQ-016 SHALL have port crc_valid, output, 1: one-cycle pulse; crc_out and crc_ok are updated.
REQ-017 SHALL have port crc_ok, output, 1: check-mode verdict; always 0 in generate mode.
REQ-018 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-019 SHALL implement the states IDLE, ACCEPT, SHIFT and DONE.
REQ-020 In IDLE, start=1 SHALL load the register with INIT, latch mode and move to ACCEPT the next cycle.
REQ-021 In ACCEPT, in_ready SHALL be 1; in_valid=1 SHALL latch in_data and in_last, load the bit counter with DATA_W-1 and move to SHIFT.
REQ-022 in_ready SHALL be 0 in IDLE, SHIFT and DONE; words presented then SHALL be ignored and not consumed.
REQ-023 Each SHIFT cycle SHALL compute fb = reg[CRC_W-1] XOR data[DATA_W-1], set reg = (reg<<1) XOR (fb ? POLY : 0), and shift data left by 1.
REQ-024 SHIFT SHALL last exactly DATA_W cycles, then go to DONE if last was latched, otherwise to ACCEPT.
REQ-025 DONE SHALL last one cycle: crc_valid=1, crc_out = reg XOR XOROUT, crc_ok = (latched mode==0) AND (reg==RESIDUE); then go to IDLE.
REQ-026 crc_out and crc_ok SHALL hold their value from DONE until the next DONE or reset.
REQ-027 Latency SHALL be fixed: if the last word is accepted at edge T, crc_valid SHALL be high in the cycle after edge T+DATA_W.
REQ-028 Peak throughput SHALL be one word per DATA_W+1 cycles.
REQ-029 start outside IDLE SHALL be ignored, and mode changes outside the start-acceptance cycle SHALL have no effect.
REQ-030 Frames SHALL contain at least one word; there SHALL be no zero-length frame.
REQ-031 In check mode the stream SHALL be the message followed by its CRC words, MSB first.
REQ-032 All arithmetic SHALL be modulo 2^CRC_W; the polynomial's top bit SHALL be implicit and never stored.

Reset
REQ-033 rst=1 SHALL force IDLE at the next edge from any state, including mid-SHIFT, and discard the frame.
REQ-034 On reset, crc_out=0, crc_valid=0, crc_ok=0, busy=0 and in_ready=0; the internal register and counter SHALL be cleared to 0.
REQ-035 rst SHALL take priority over start and in_valid in the same cycle.

Verification
REQ-036 Defaults, generate, single word 0x01 -> crc_out=0x04C11DB7 and crc_ok=0; crc_valid exactly 9 cycles after acceptance.
REQ-037 INIT=32'hFFFFFFFF, generate, ASCII "123456789" -> crc_out=0x0376E6E7.
REQ-038 Same parameters, check, "123456789" then 0x03,0x76,0xE6,0xE7 -> crc_ok=1; with one bit flipped -> crc_ok=0.
REQ-039 INIT=0, XOROUT=32'hFFFFFFFF, "123456789" -> crc_out=0x765E7680.
REQ-040 in_valid held high through SHIFT -> exactly one word consumed per ACCEPT; start pulsed while busy -> no effect.
REQ-041 rst asserted in the 4th SHIFT cycle -> IDLE next cycle, crc_valid never pulses, all outputs at reset values; a new frame then computes correctly.
